// File: rtl/iterative_normalizer_pkg.sv
// Shared types for the iterative normalizer.
// FSM encoding and default datapath width.
package iterative_normalizer_pkg;

  localparam int DEFAULT_N = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/iterative_normalizer_normalize_stage.sv
// One binary-search step: test the top 2^k bits
// and shift them out when they are all zero.
module normalize_stage
  import iterative_normalizer_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] data,
  input  logic [W-1:0] k,
  output logic [N-1:0] shifted,
  output logic         hit
);

  logic [W:0] step;
  logic [W:0] tail;

  assign step    = (W+1)'(1) << k;
  assign tail    = (W+1)'(N) - step;
  assign hit     = (data >> tail) == '0;
  assign shifted = hit ? (data << step) : data;

endmodule

// File: rtl/iterative_normalizer.sv
// Multi-cycle leading-zero normalizer: W search
// steps share one normalize_stage.
module iterative_normalizer
  import iterative_normalizer_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = $clog2(N)
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         In_Valid,
  output logic         In_Ready,
  input  logic [N-1:0] Input,
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic [N-1:0] Result,
  output logic [W-1:0] Shift_Count,
  output logic         Zero
);

  state_t state;
  state_t state_nxt;

  logic [N-1:0] work;
  logic [N-1:0] stage_out;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] k;
  logic         hit;
  logic         load;
  logic         last;

  assign In_Ready = (state == IDLE) ||
                    ((state == DONE) && Out_Ready);
  assign load     = In_Valid && In_Ready;
  assign last     = (k == '0);

  normalize_stage #(
    .N(N),
    .W(W)
  ) u_stage (
    .data   (work),
    .k      (k),
    .shifted(stage_out),
    .hit    (hit)
  );

  always_comb begin
    cnt_nxt    = cnt;
    cnt_nxt[k] = hit;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (In_Valid) state_nxt = SEARCH;
      end
      SEARCH: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (Out_Ready) begin
          state_nxt = In_Valid ? SEARCH : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are captured on the final step and
  // then held untouched until the consumer takes them.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      work        <= '0;
      cnt         <= '0;
      k           <= '0;
      Out_Valid   <= 1'b0;
      Result      <= '0;
      Shift_Count <= '0;
      Zero        <= 1'b0;
    end else if (load) begin
      work      <= Input;
      cnt       <= '0;
      k         <= W'(W-1);
      Out_Valid <= 1'b0;
    end else if (state == SEARCH) begin
      work <= stage_out;
      cnt  <= cnt_nxt;
      k    <= k - 1'b1;
      if (last) begin
        Out_Valid   <= 1'b1;
        Result      <= stage_out;
        Shift_Count <= cnt_nxt;
        Zero        <= (stage_out == '0);
      end
    end else if ((state == DONE) && Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

endmodule

// File: doc/iterative_normalizer.md
ITERATIVE_NORMALIZER -- requirements
Module: iterative_normalizer

Interface
REQ-001 Parameter N, default 32, datapath width; SHALL be a power of two and at least 4.
REQ-002 Parameter W, default $clog2(N), shift-count width; derived, not overridden.
REQ-003 Clock  input  1  single clock, all state rising-edge triggered.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 In_Valid  input  1  Input holds an operand to normalize.
REQ-006 In_Ready  output  1  block can accept an operand this cycle.
REQ-007 Input  input  N  operand, unsigned.
REQ-008 Out_Valid  output  1  Result, Shift_Count and Zero are valid.
REQ-009 Out_Ready  input  1  consumer accepts the result this cycle.
REQ-010 Result  output  N  Input shifted left until bit N-1 is 1.
REQ-011 Shift_Count  output  W  left-shift amount applied, i.e. leading-zero count of Input.
REQ-012 Zero  output  1  Input was all zeros.

Function
REQ-013 The block SHALL compute the shift that a left barrel shift needs to normalize an operand: Result = Input << Shift_Count, with Result[N-1] = 1 for nonzero Input.
REQ-014 FSM states IDLE, SEARCH, DONE; reset state IDLE.
REQ-015 In_Ready = 1 in IDLE, and in DONE when Out_Ready = 1; otherwise 0.
REQ-016 Input handshake (In_Valid & In_Ready) SHALL load Input into the working register, clear the count, set stage index k = W-1, go to SEARCH.
REQ-017 SEARCH, per cycle: if the top 2^k bits of the working register are all zero, shift it left by 2^k and set count bit k; else leave both unchanged.
REQ-018 SEARCH SHALL run exactly W cycles, k = W-1 down to 0, then go to DONE.
REQ-019 Latency: Out_Valid asserts W+1 cycles after the input handshake cycle (5+1 = 6 for N=32).
REQ-020 DONE: Out_Valid = 1; Result, Shift_Count and Zero SHALL stay stable until Out_Ready = 1.
REQ-021 DONE with Out_Ready = 1 and In_Valid = 0 -> IDLE; with In_Valid = 1 -> new operand loaded, SEARCH (no bubble cycle).
REQ-022 Zero input: Result = 0, Shift_Count = N-1 (all ones), Zero = 1.
REQ-023 Input with bit N-1 set: Shift_Count = 0, Result = Input, Zero = 0.
REQ-024 In_Valid while busy (SEARCH, or DONE without Out_Ready) SHALL be ignored; Input is not sampled.
REQ-025 Out_Valid, Result, Shift_Count and Zero SHALL be registered outputs.

Reset
REQ-026 Reset_n low SHALL immediately force IDLE, In_Ready = 1, Out_Valid = 0, Result = 0, Shift_Count = 0, Zero = 0, working register and count = 0.
REQ-027 Reset mid-SEARCH or mid-DONE SHALL abandon the operation; no result is produced after release.
REQ-028 The first input handshake is permitted on the first rising edge after Reset_n deasserts.

Structure
REQ-029 FSM state encoding and default N SHALL live in the shared ALU package.
REQ-030 One sub-module, normalize_stage: combinational zero-test and conditional shift by 2^k for a runtime k; instantiated once and reused across SEARCH cycles.
REQ-031 The W-cycle iterative search SHALL NOT be replaced by a single-cycle priority encoder.

Verification (N=32)
REQ-032 Input 0x00000001 -> after 6 cycles Out_Valid = 1, Result 0x80000000, Shift_Count 31, Zero 0.
REQ-033 Inputs 0x80000000 and 0x00000000 -> (0x80000000, 0, Zero 0) and (0x00000000, 31, Zero 1).
REQ-034 Input 0x0000F00F, Out_Ready held low 10 cycles -> outputs stable at 0xF00F0000, count 16 throughout; In_Ready = 0 throughout.
REQ-035 Back-to-back: Out_Ready and In_Valid held high, operands 0x00010000 then 0x00000300 -> (0x80000000, 15) then (0xC0000000, 22), one result every 6 cycles.
REQ-036 Reset_n pulsed low during SEARCH cycle 3 -> all outputs 0 at once, IDLE, no Out_Valid after release.
REQ-037 Random sweep, 10k operands -> Result and Shift_Count match a leading-zero reference model.
